// File: rtl/gaussian_nb_sdiv_39s_23s_16_seq.sv
// rtl/gaussian_nb_sdiv_39s_23s_16_seq.sv - sequential 39s/23s signed divider, saturated 16b quotient (remainder port under GAUSSIAN_NB_SDIV_REM_EN)
module gaussian_nb_sdiv_39s_23s_16_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd39,
  parameter int unsigned din1_WIDTH = 32'd23,
  parameter int unsigned dout_WIDTH = 32'd16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
`ifdef GAUSSIAN_NB_SDIV_REM_EN
  output logic [din1_WIDTH-1:0] rem,
`endif
  output logic                  dbz
);

  // The instance tag has no functional effect; this empty block only anchors it.
  if (ID == 32'hFFFF_FFFF) begin : g_id_tag
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [38:0] dvd_q, dvd_d;    // dividend magnitude, consumed MSB first
  logic [22:0] dvs_q, dvs_d;    // divisor magnitude
  logic [22:0] prem_q, prem_d;  // partial remainder; always < divisor so 23b holds it
  logic [38:0] quo_q, quo_d;    // unsigned quotient magnitude
  logic        sgn0_q, sgn0_d, sgn1_q, sgn1_d, zero_q, zero_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] dout_q, dout_d;
  logic        ovf_q, ovf_d, dbz_q, dbz_d;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
  logic [22:0] din0_lo_q, din0_lo_d;
  logic [22:0] rem_q, rem_d;
`endif

  logic [38:0] mag0;
  logic [22:0] mag1;
  logic [23:0] trial;
  logic [22:0] diff;
  logic        geq;

  // -2^38 negates to 2^38, which the 39b unsigned magnitude represents exactly.
  assign mag0  = din0[38] ? (~din0 + 39'd1) : din0;
  assign mag1  = din1[22] ? (~din1 + 23'd1) : din1;
  assign trial = {prem_q, dvd_q[38]};
  assign geq   = (trial >= {1'b0, dvs_q});
  assign diff  = trial[22:0] - dvs_q;

  assign in_ready  = (state_q == IDLE) && ce;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
  assign rem       = rem_q;
`endif

  // Next-state logic: operand capture, one restoring step per cycle, sign/saturation fix-up, handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    sgn0_d      = sgn0_q;
    sgn1_d      = sgn1_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
    din0_lo_d   = din0_lo_q;
    rem_d       = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          dvd_d   = mag0;
          dvs_d   = mag1;
          sgn0_d  = din0[38];
          sgn1_d  = din1[22];
          zero_d  = (din1 == '0);
          prem_d  = '0;
          quo_d   = '0;
          cnt_d   = 6'd38;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
          din0_lo_d = din0[22:0];
`endif
        end
      end
      CALC: begin
        prem_d = geq ? diff : trial[22:0];
        quo_d  = {quo_q[37:0], geq};
        dvd_d  = {dvd_q[37:0], 1'b0};
        if (cnt_q == 6'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 6'd1;
      end
      FIX: begin
        dbz_d = zero_q;
        ovf_d = 1'b0;
        if (zero_q) begin
          dout_d = sgn0_q ? 16'h8000 : 16'h7FFF;
        end else if (sgn0_q ^ sgn1_q) begin
          if (quo_q > 39'd32768) begin
            dout_d = 16'h8000;
            ovf_d  = 1'b1;
          end else begin
            dout_d = ~quo_q[15:0] + 16'd1;
          end
        end else begin
          if (quo_q > 39'd32767) begin
            dout_d = 16'h7FFF;
            ovf_d  = 1'b1;
          end else begin
            dout_d = quo_q[15:0];
          end
        end
`ifdef GAUSSIAN_NB_SDIV_REM_EN
        if (zero_q)      rem_d = din0_lo_q;
        else if (sgn0_q) rem_d = ~prem_q + 23'd1;
        else             rem_d = prem_q;
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register: reset wins, otherwise ce=0 freezes every register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      sgn0_q      <= 1'b0;
      sgn1_q      <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
      din0_lo_q   <= '0;
      rem_q       <= '0;
`endif
    end else if (ce) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      sgn0_q      <= sgn0_d;
      sgn1_q      <= sgn1_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
      din0_lo_q   <= din0_lo_d;
      rem_q       <= rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_gaussian_nb_sdiv_39s_23s_16_seq.sv
// tb/tb_gaussian_nb_sdiv_39s_23s_16_seq.sv - self-checking bench for the sequential signed divider
module tb_gaussian_nb_sdiv_39s_23s_16_seq;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, out_ready;
  logic        in_ready, out_valid, ovf, dbz;
  logic [38:0] din0;
  logic [22:0] din1;
  logic [15:0] dout;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
  logic [22:0] rem;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gaussian_nb_sdiv_39s_23s_16_seq #(
    .ID(32'd1), .din0_WIDTH(32'd39), .din1_WIDTH(32'd23), .dout_WIDTH(32'd16)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf),
`ifdef GAUSSIAN_NB_SDIV_REM_EN
    .rem(rem),
`endif
    .dbz(dbz)
  );

  typedef struct {
    logic [38:0] a;
    logic [22:0] b;
    logic [15:0] q;
    logic        o;
    logic        z;
    logic [22:0] r;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division truncating toward zero, then clamp.
  function automatic void model(input logic [38:0] a, input logic [22:0] b,
                                output logic [15:0] q, output logic o,
                                output logic z, output logic [22:0] r);
    longint la, lb, lq, lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      z = 1'b1; o = 1'b0;
      q = (la < 0) ? 16'h8000 : 16'h7FFF;
      r = a[22:0];
    end else begin
      lq = la / lb;
      lr = la % lb;
      z = 1'b0; o = 1'b0;
      if (lq > 32767)       begin q = 16'h7FFF; o = 1'b1; end
      else if (lq < -32768) begin q = 16'h8000; o = 1'b1; end
      else                  q = lq[15:0];
      r = lr[22:0];
    end
  endfunction

  // One operation; lat counts negedges after the accept edge until out_valid shows (cycle number).
  task automatic run_op(input logic [38:0] a, input logic [22:0] b,
                        input int stall_at, input int stall_len, input int hold,
                        output logic [15:0] q, output logic o, output logic z,
                        output logic [22:0] r, output int lat);
    int w;
    logic [15:0] q0;
    @(negedge clk);
    din0 = a; din1 = b; in_valid = 1'b1; out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (stall_len > 0 && lat == stall_at) ce = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) ce = 1'b1;
      if (out_valid) break;
    end
    ce = 1'b1;
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    q = dout; o = ovf; z = dbz;
`ifdef GAUSSIAN_NB_SDIV_REM_EN
    r = rem;
`else
    r = '0;
`endif
    q0 = dout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_dout_stable", {48'd0, dout}, {48'd0, q0});
      chk("hold_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_out_valid_low", {63'd0, out_valid}, 64'd0);
    chk("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_res(input string tag, input vec_t v, input logic [15:0] q,
                           input logic o, input logic z, input logic [22:0] r);
    chk({tag, "_dout"}, {48'd0, q}, {48'd0, v.q});
    chk({tag, "_ovf"}, {63'd0, o}, {63'd0, v.o});
    chk({tag, "_dbz"}, {63'd0, z}, {63'd0, v.z});
`ifdef GAUSSIAN_NB_SDIV_REM_EN
    chk({tag, "_rem"}, {41'd0, r}, {41'd0, v.r});
`endif
  endtask

  vec_t        vt[14];
  vec_t        rv;
  logic [15:0] q;
  logic        o, z;
  logic [22:0] r;
  int          lat;
  int          acc_t[$];

  initial begin
    vt[0]  = '{39'd1000, 23'd10, 16'd100, 1'b0, 1'b0, 23'd0};
    vt[1]  = '{-39'sd7, 23'd2, 16'hFFFD, 1'b0, 1'b0, 23'h7FFFFF};
    vt[2]  = '{39'd7, -23'sd2, 16'hFFFD, 1'b0, 1'b0, 23'd1};
    vt[3]  = '{-39'sd7, -23'sd2, 16'd3, 1'b0, 1'b0, 23'h7FFFFF};
    vt[4]  = '{39'd1048576, 23'd1, 16'h7FFF, 1'b1, 1'b0, 23'd0};
    vt[5]  = '{39'h40_0000_0000, 23'd1, 16'h8000, 1'b1, 1'b0, 23'd0};
    vt[6]  = '{-39'sd32768, 23'd1, 16'h8000, 1'b0, 1'b0, 23'd0};
    vt[7]  = '{39'd32767, 23'd1, 16'h7FFF, 1'b0, 1'b0, 23'd0};
    vt[8]  = '{39'd32768, 23'd1, 16'h7FFF, 1'b1, 1'b0, 23'd0};
    vt[9]  = '{39'd5, 23'd0, 16'h7FFF, 1'b0, 1'b1, 23'd5};
    vt[10] = '{-39'sd5, 23'd0, 16'h8000, 1'b0, 1'b1, 23'h7FFFFB};
    vt[11] = '{39'd100, -23'sd3, 16'hFFDF, 1'b0, 1'b0, 23'd1};
    vt[12] = '{39'h3F_FFFF_FFFF, 23'h40_0000, 16'h8000, 1'b1, 1'b0, 23'h3FFFFF};
    vt[13] = '{-39'sd100, 23'd7, 16'hFFF2, 1'b0, 1'b0, 23'h7FFFFE};

    reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dout", {48'd0, dout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_dbz", {63'd0, dbz}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].a, vt[i].b, 0, 0, 0, q, o, z, r, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd41);
      check_res($sformatf("vec%0d", i), vt[i], q, o, z, r);
    end

    // ce held low for 10 cycles mid-CALC stretches latency to 51.
    run_op(39'd1000, 23'd10, 5, 10, 0, q, o, z, r, lat);
    chk("stall_latency", 64'(lat), 64'd51);
    check_res("stall", vt[0], q, o, z, r);

    // out_ready low for 5 cycles in DONE.
    run_op(-39'sd7, -23'sd2, 0, 0, 5, q, o, z, r, lat);
    check_res("backpressure", vt[3], q, o, z, r);

    // Reset at cycle 20 of an operation aborts it.
    @(negedge clk);
    din0 = 39'd42; din1 = 23'd1; in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_dout", {48'd0, dout}, 64'd0);
    chk("abort_ovf", {63'd0, ovf}, 64'd0);
    chk("abort_dbz", {63'd0, dbz}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (out_valid) chk("abort_no_result", 64'd1, 64'd0);
    end
    run_op(39'd100, -23'sd3, 0, 0, 0, q, o, z, r, lat);
    chk("after_reset_latency", 64'(lat), 64'd41);
    check_res("after_reset", vt[11], q, o, z, r);

    // Random operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      rv.a = {$urandom, $urandom};
      rv.b = 23'($urandom);
      case (i % 4)
        1: rv.a = 39'($signed(17'($urandom)));
        2: rv.b = 23'($signed(6'($urandom)));
        3: begin rv.a = 39'($signed(28'($urandom))); rv.b = 23'($signed(12'($urandom))); end
        default: ;
      endcase
      model(rv.a, rv.b, rv.q, rv.o, rv.z, rv.r);
      run_op(rv.a, rv.b, 0, 0, 0, q, o, z, r, lat);
      check_res($sformatf("rand%0d", i), rv, q, o, z, r);
    end

    // Back-to-back: in_valid held high, accept interval is 42 cycles.
    @(negedge clk);
    din0 = 39'd1000; din1 = 23'd10; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 130; c++) begin
      if (in_ready) acc_t.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_t.size() >= 3), 64'd1);
    if (acc_t.size() >= 3) begin
      chk("b2b_gap1", 64'(acc_t[1] - acc_t[0]), 64'd42);
      chk("b2b_gap2", 64'(acc_t[2] - acc_t[1]), 64'd42);
    end
    for (int c = 0; c < 100 && !in_ready; c++) @(negedge clk);
    chk("b2b_drain", {63'd0, in_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
